uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with receive FIFO.
package uart_pkg;

    localparam int unsigned OSR16         = 16;
    localparam int unsigned OSR13         = 13;
    localparam int unsigned MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef struct packed {
        logic                     frm_err;
        logic                     par_err;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

    function automatic logic [3:0] osr_half(input logic osm_sel);
        return osm_sel ? 4'(OSR13 / 2) : 4'(OSR16 / 2);
    endfunction

    function automatic logic [3:0] osr_last(input logic osm_sel);
        return osm_sel ? 4'(OSR13 - 1) : 4'(OSR16 - 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Head data reads as zero while the FIFO is empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (x16/x13 oversampling, optional parity) feeding a receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic                          rx_serial,
    input  logic                          cfg_pen,
    input  logic                          cfg_eps,
    input  logic                          cfg_osm_sel,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_par_err,
    output logic                          rd_frm_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          rx_busy
);

    rx_state_e state_q, state_d;
    logic                     sync1_q, sync2_q;
    logic [3:0]               cnt_q, cnt_d;
    logic [2:0]               bit_q, bit_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     pen_q, pen_d;
    logic                     eps_q, eps_d;
    logic                     osm_q, osm_d;
    logic                     par_err_q, par_err_d;
    logic                     overrun_q, overrun_d;

    logic       rx_s;
    logic [3:0] half;
    logic [3:0] last;
    logic [3:0] cnt_nxt;
    logic       end_bit;
    logic       dec_tick;
    logic       bit_v;
    logic       exp_par;
    logic       push;
    logic       full;
    logic       drop;
    rx_entry_t  wentry;
    rx_entry_t  head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s    = sync2_q;
    assign half    = osr_half(osm_q);
    assign last    = osr_last(osm_q);
    assign end_bit = (cnt_q == last);
    assign cnt_nxt = end_bit ? 4'd0 : cnt_q + 4'd1;
    assign exp_par = eps_q ? ^shift_q : ~^shift_q;

`ifdef UART_RX_MAJORITY_EN
    logic s_early_q;
    logic s_mid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_early_q <= 1'b1;
            s_mid_q   <= 1'b1;
        end else if (baud_tick && state_q != IDLE) begin
            if (cnt_q == half - 4'd1) begin
                s_early_q <= rx_s;
            end
            if (cnt_q == half) begin
                s_mid_q <= rx_s;
            end
        end
    end

    // Decision lands on the third sample; bit boundaries are unchanged
    assign dec_tick = (cnt_q == half + 4'd1);
    assign bit_v    = (s_early_q & s_mid_q) | (s_early_q & rx_s) |
                      (s_mid_q & rx_s);
`else
    assign dec_tick = (cnt_q == half);
    assign bit_v    = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        osm_d     = osm_q;
        par_err_d = par_err_q;
        push      = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        // The detecting tick counts as tick 0 of the start bit
                        state_d   = START;
                        cnt_d     = 4'd1;
                        bit_d     = 3'd0;
                        shift_d   = '0;
                        par_err_d = 1'b0;
                        pen_d     = cfg_pen;
                        eps_d     = cfg_eps;
                        osm_d     = cfg_osm_sel;
                    end
                end
                START: begin
                    cnt_d = cnt_nxt;
                    if (dec_tick && bit_v) begin
                        state_d = IDLE;
                    end else if (end_bit) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    cnt_d = cnt_nxt;
                    if (dec_tick) begin
                        shift_d[bit_q] = bit_v;
                    end
                    if (end_bit) begin
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_d   = 3'd0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    cnt_d = cnt_nxt;
                    if (dec_tick) begin
                        par_err_d = (bit_v != exp_par);
                    end
                    if (end_bit) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    cnt_d = cnt_nxt;
                    if (dec_tick) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            osm_q     <= 1'b0;
            par_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            osm_q     <= osm_d;
            par_err_q <= par_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign wentry.frm_err = ~bit_v;
    assign wentry.par_err = par_err_q;
    assign wentry.data    = shift_q;

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (rd_ready),
        .valid_o (rd_valid),
        .full_o  (full),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    // Set wins over a same-cycle clear so no drop goes unreported
    assign drop      = push && full && !(rd_valid && rd_ready);
    assign overrun_d = drop || (overrun_q && !clr_overrun);

    assign rd_data    = head.data[DATA_BITS-1:0];
    assign rd_par_err = head.par_err;
    assign rd_frm_err = head.frm_err;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8-bit instance and a 5-bit instance.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       baud_tick = 1'b0;
    logic [1:0] div = 2'd0;

    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       osm = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       par_err;
    logic       frm_err;
    logic [4:0] count;
    logic       ovr;
    logic       busy;

    logic       rst5 = 1'b0;
    logic       rx5 = 1'b1;
    logic       rd_valid5;
    logic [4:0] rd_data5;
    logic       par_err5;
    logic       frm_err5;
    logic [4:0] count5;
    logic       ovr5;
    logic       busy5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        baud_tick = (div == 2'd3);
        div = div + 2'd1;
    end

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16)) u8 (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx_serial   (rx),
        .cfg_pen     (pen),
        .cfg_eps     (eps),
        .cfg_osm_sel (osm),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_par_err  (par_err),
        .rd_frm_err  (frm_err),
        .fifo_count  (count),
        .overrun     (ovr),
        .clr_overrun (clr),
        .rx_busy     (busy)
    );

    uart_rx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(16)) u5 (
        .clk         (clk),
        .rst         (rst5),
        .baud_tick   (baud_tick),
        .rx_serial   (rx5),
        .cfg_pen     (1'b0),
        .cfg_eps     (1'b0),
        .cfg_osm_sel (1'b0),
        .rd_valid    (rd_valid5),
        .rd_ready    (1'b0),
        .rd_data     (rd_data5),
        .rd_par_err  (par_err5),
        .rd_frm_err  (frm_err5),
        .fifo_count  (count5),
        .overrun     (ovr5),
        .clr_overrun (1'b0),
        .rx_busy     (busy5)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input bit five, input logic v);
        if (five) rx5 = v;
        else rx = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input bit with_par, input logic par_bit,
                              input logic stop_bit, input int osr,
                              input bit five);
        drive(five, 1'b0);
        tick_wait(osr);
        for (int i = 0; i < nb; i++) begin
            drive(five, d[i]);
            tick_wait(osr);
        end
        if (with_par) begin
            drive(five, par_bit);
            tick_wait(osr);
        end
        drive(five, stop_bit);
        tick_wait(osr);
        drive(five, 1'b1);
        tick_wait(2 * osr);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        repeat (6) @(posedge clk);
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_overrun", ovr, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rd_data, 0);
        check("rst_par", par_err, 0);
        check("rst_frm", frm_err, 0);
        rst = 1'b1;
        rst5 = 1'b1;
        tick_wait(2);

        send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 16, 0);
        @(negedge clk);
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_par", par_err, 0);
        check("a5_frm", frm_err, 0);
        check("a5_count", count, 1);
        pop();
        check("a5_popped", count, 0);

        pen = 1'b1;
        eps = 1'b1;
        osm = 1'b1;
        send_frame(8'hD3, 8, 1, 1'b1, 1'b1, 13, 0);
        @(negedge clk);
        check("d3_good_valid", rd_valid, 1);
        check("d3_good_data", rd_data, 8'hD3);
        check("d3_good_par", par_err, 0);
        pop();
        send_frame(8'hD3, 8, 1, 1'b0, 1'b1, 13, 0);
        @(negedge clk);
        check("d3_bad_data", rd_data, 8'hD3);
        check("d3_bad_par", par_err, 1);
        check("d3_bad_frm", frm_err, 0);
        pop();

        pen = 1'b0;
        eps = 1'b0;
        osm = 1'b0;
        send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 16, 0);
        @(negedge clk);
        check("3c_count", count, 1);
        check("3c_data", rd_data, 8'h3C);
        check("3c_frm", frm_err, 1);
        check("3c_par", par_err, 0);
        pop();
        check("3c_popped", count, 0);

        rx = 1'b0;
        tick_wait(4);
        rx = 1'b1;
        check("glitch_busy", busy, 1);
        tick_wait(16);
        check("glitch_idle", busy, 0);
        check("glitch_count", count, 0);
        check("glitch_valid", rd_valid, 0);

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 8, 0, 1'b0, 1'b1, 16, 0);
        end
        @(negedge clk);
        check("full_count", count, 16);
        check("full_overrun", ovr, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("pop%0d", i), rd_data, i);
            pop();
        end
        check("drain_count", count, 0);
        check("drain_valid", rd_valid, 0);
        check("ovr_sticky", ovr, 1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("ovr_cleared", ovr, 0);

        rx5 = 1'b0;
        tick_wait(16);
        rx5 = 1'b1;
        tick_wait(16);
        rx5 = 1'b0;
        tick_wait(16);
        rx5 = 1'b1;
        tick_wait(8);
        check("b5_busy_mid", busy5, 1);
        rst5 = 1'b0;
        #2;
        check("b5_rst_busy", busy5, 0);
        check("b5_rst_valid", rd_valid5, 0);
        tick_wait(8);
        rst5 = 1'b1;
        tick_wait(32);
        check("b5_after_valid", rd_valid5, 0);
        check("b5_after_count", count5, 0);
        send_frame(8'h0A, 5, 0, 1'b0, 1'b1, 16, 1);
        @(negedge clk);
        check("b5_valid", rd_valid5, 1);
        check("b5_data", rd_data5, 5'h0A);
        check("b5_frm", frm_err5, 0);
        check("b5_par", par_err5, 0);
        check("b5_count", count5, 1);
        check("b5_overrun", ovr5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
